// File: rtl/decode_pkg.sv
// Shared decode definitions: ALU opcodes, instruction field enums, the
// accumulator register index and the packed decoded-op record.
package decode_pkg;

  localparam int unsigned NUM_REGS_P = 12;
  localparam int unsigned RA_W       = $clog2(NUM_REGS_P + 1);
  localparam int unsigned IMM_W      = 8;
  localparam int unsigned ALU_W      = 4;

  localparam logic [RA_W-1:0] ACC = RA_W'(NUM_REGS_P);

  localparam logic [ALU_W-1:0] ALU_AND = 4'd0;
  localparam logic [ALU_W-1:0] ALU_SLT = 4'd1;
  localparam logic [ALU_W-1:0] ALU_OR  = 4'd2;
  localparam logic [ALU_W-1:0] ALU_NOT = 4'd3;
  localparam logic [ALU_W-1:0] ALU_ADD = 4'd4;
  localparam logic [ALU_W-1:0] ALU_SUB = 4'd5;
  localparam logic [ALU_W-1:0] ALU_PASS = 4'd6;
  localparam logic [ALU_W-1:0] ALU_BEQ = 4'd7;
  localparam logic [ALU_W-1:0] ALU_SRL = 4'd8;
  localparam logic [ALU_W-1:0] ALU_SRA = 4'd9;
  localparam logic [ALU_W-1:0] ALU_SLL = 4'd10;

  typedef enum logic [2:0] {
    OP_RTYPE = 3'b000,
    OP_MEM   = 3'b001,
    OP_ADD   = 3'b010,
    OP_ADDI  = 3'b011,
    OP_SUB   = 3'b100,
    OP_TR    = 3'b101,
    OP_JR    = 3'b110,
    OP_SHIFT = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    SUB_0 = 2'd0,
    SUB_1 = 2'd1,
    SUB_2 = 2'd2,
    SUB_3 = 2'd3
  } sub_e;

  typedef struct packed {
    logic [ALU_W-1:0] alu;
    logic [RA_W-1:0]  rs;
    logic [RA_W-1:0]  rt;
    logic [RA_W-1:0]  rd;
    logic [IMM_W-1:0] imm;
    logic             reg_write;
    logic             car_write;
    logic             sel_imm;
    logic             jump;
    logic             mem_read;
    logic             mem_write;
    logic             mem2reg;
    logic             done;
  } decoded_op_t;

endpackage

// File: rtl/decode_logic.sv
// Combinational instruction decoder: raw instruction bits [8:0] to a
// decoded_op_t; every field not used by an op stays 0.
module decode_logic
  import decode_pkg::*;
#(
  parameter int INSTR_WIDTH = 9
) (
  input  logic [INSTR_WIDTH-1:0] i_instr,
  output decoded_op_t            o_op
);

  logic [8:0]      w_i;
  op_e             w_opc;
  sub_e            w_sub;
  logic [RA_W-1:0] w_f54;
  logic [RA_W-1:0] w_f32;

  assign w_i   = i_instr[8:0];
  assign w_opc = op_e'(w_i[8:6]);
  assign w_sub = sub_e'(w_i[1:0]);
  assign w_f54 = RA_W'(w_i[5:4]);
  assign w_f32 = RA_W'(w_i[3:2]);

  // Decode table.
  always_comb begin
    o_op = '0;
    case (w_opc)
      OP_RTYPE: begin
        if (w_sub == SUB_3) begin
          o_op.alu = ALU_BEQ;
          o_op.rs  = w_f54;
          o_op.rt  = w_f32 + RA_W'(8);
        end else begin
          o_op.alu       = {2'b00, w_sub};
          o_op.rs        = w_f54 + RA_W'(4);
          o_op.rt        = w_f32;
          o_op.rd        = ACC;
          o_op.reg_write = 1'b1;
        end
      end
      OP_MEM: begin
        case (w_sub)
          SUB_0: begin
            o_op.alu       = ALU_PASS;
            o_op.rs        = w_f32;
            o_op.rd        = w_f54 + RA_W'(4);
            o_op.reg_write = 1'b1;
            o_op.mem_read  = 1'b1;
            o_op.mem2reg   = 1'b1;
          end
          SUB_1: begin
            o_op.alu       = ALU_PASS;
            o_op.rs        = w_f54 + RA_W'(4);
            o_op.rt        = w_f32;
            o_op.mem_write = 1'b1;
          end
          SUB_2: begin
            o_op.alu       = ALU_ADD;
            o_op.rs        = RA_W'(w_i[5:2]);
            o_op.rd        = RA_W'(w_i[5:2]);
            o_op.imm       = IMM_W'(1);
            o_op.sel_imm   = 1'b1;
            o_op.reg_write = 1'b1;
          end
          default: begin
            o_op.alu       = ALU_NOT;
            o_op.rs        = RA_W'(w_i[5:2]);
            o_op.rd        = RA_W'(w_i[5:2]);
            o_op.reg_write = 1'b1;
          end
        endcase
      end
      OP_ADD, OP_SUB: begin
        o_op.alu       = (w_opc == OP_ADD) ? ALU_ADD : ALU_SUB;
        o_op.rs        = w_f54 + RA_W'(4);
        o_op.rt        = w_f32;
        o_op.rd        = RA_W'(w_i[1:0]) + RA_W'(8);
        o_op.reg_write = 1'b1;
        o_op.car_write = 1'b1;
      end
      OP_ADDI: begin
        o_op.alu       = ALU_ADD;
        o_op.rs        = w_f32;
        o_op.rd        = w_f54 + RA_W'(8);
        o_op.imm       = IMM_W'(w_i[1:0]);
        o_op.sel_imm   = 1'b1;
        o_op.reg_write = 1'b1;
      end
      OP_TR: begin
        o_op.alu       = ALU_PASS;
        o_op.rs        = RA_W'(w_i[2:0]) + RA_W'(5);
        o_op.rd        = RA_W'(w_i[5:3]) + RA_W'(1);
        o_op.reg_write = 1'b1;
      end
      OP_JR: begin
        o_op.alu  = ALU_PASS;
        o_op.imm  = {{(IMM_W-6){w_i[5]}}, w_i[5:0]};
        o_op.jump = 1'b1;
      end
      OP_SHIFT: begin
        if (w_sub == SUB_3) begin
          o_op.done = 1'b1;
        end else begin
          o_op.alu       = ALU_SRL + {2'b00, w_sub};
          o_op.rs        = w_f54 + RA_W'(4);
          o_op.rd        = w_f54 + RA_W'(4);
          o_op.rt        = w_f32;
          o_op.reg_write = 1'b1;
          o_op.car_write = 1'b1;
        end
      end
      default: o_op = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: decodes accepted instructions into a DEPTH-entry FIFO of ops.
// Optional perf counters (issue_cnt/stall_cnt) are built under DECODE_PERF_EN.
module decode_stage
  import decode_pkg::*;
#(
  parameter int NUM_REGS    = 12,
  parameter int INSTR_WIDTH = 9,
  parameter int REG_WIDTH   = 8,
  parameter int OP_WIDTH    = 4,
  parameter int DEPTH       = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic [INSTR_WIDTH-1:0]        instruction,
  output logic                          in_ready,
  input  logic                          flush,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OP_WIDTH-1:0]           alu_op,
  output logic [$clog2(NUM_REGS+1)-1:0] rs_addr,
  output logic [$clog2(NUM_REGS+1)-1:0] rt_addr,
  output logic [$clog2(NUM_REGS+1)-1:0] rd_addr,
  output logic [REG_WIDTH-1:0]          imm,
  output logic                          reg_write,
  output logic                          car_write,
  output logic                          sel_imm,
  output logic                          jump,
  output logic                          mem_read,
  output logic                          mem_write,
  output logic                          mem2reg,
  output logic                          done,
  output logic                          halted,
  output logic [$clog2(DEPTH):0]        level
`ifdef DECODE_PERF_EN
  ,
  output logic [15:0]                   issue_cnt,
  output logic [15:0]                   stall_cnt
`endif
);

  localparam int RA = $clog2(NUM_REGS + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  decoded_op_t       r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [LW-1:0]     r_level;
  logic              r_halted;
  decoded_op_t       w_dec;
  decoded_op_t       w_head;
  logic              w_push;
  logic              w_pop;

  decode_logic #(.INSTR_WIDTH(INSTR_WIDTH)) u_decode (
    .i_instr (instruction),
    .o_op    (w_dec)
  );

  assign out_valid = (r_level != '0);
  assign in_ready  = rst_n && !r_halted && ((r_level < LW'(DEPTH)) || out_ready);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  // Queue storage, pointers and occupancy; a popped DONE drops everything behind it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_halted <= 1'b0;
      for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (w_pop && w_head.done) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_halted <= 1'b1;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_dec;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Head entry, forced to zero when the queue is empty.
  always_comb begin
    w_head = '0;
    if (out_valid) begin
      w_head = r_mem[r_rd_ptr];
    end else begin
      w_head = '0;
    end
  end

  assign alu_op    = OP_WIDTH'(w_head.alu);
  assign rs_addr   = RA'(w_head.rs);
  assign rt_addr   = RA'(w_head.rt);
  assign rd_addr   = RA'(w_head.rd);
  assign imm       = REG_WIDTH'(w_head.imm);
  assign reg_write = w_head.reg_write;
  assign car_write = w_head.car_write;
  assign sel_imm   = w_head.sel_imm;
  assign jump      = w_head.jump;
  assign mem_read  = w_head.mem_read;
  assign mem_write = w_head.mem_write;
  assign mem2reg   = w_head.mem2reg;
  assign done      = w_head.done;
  assign halted    = r_halted;
  assign level     = r_level;

`ifdef DECODE_PERF_EN
  logic [15:0] r_issue_cnt;
  logic [15:0] r_stall_cnt;

  // Saturating issue and stall counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_issue_cnt <= 16'd0;
      r_stall_cnt <= 16'd0;
    end else begin
      if (w_pop && !flush && (r_issue_cnt != 16'hFFFF)) begin
        r_issue_cnt <= r_issue_cnt + 16'd1;
      end
      if (out_valid && !out_ready && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end

  assign issue_cnt = r_issue_cnt;
  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: a spec-level reference decoder fills an
// expected-op queue on accept; a negedge monitor checks level/flags/head.
module tb_decode_stage;

  localparam int DEPTH = 4;
  localparam int ACC   = 12;

  logic       clk = 1'b0;
  logic       rst_n, in_valid, flush, out_ready;
  logic [8:0] instruction;
  logic       in_ready, out_valid;
  logic [3:0] alu_op, rs_addr, rt_addr, rd_addr;
  logic [7:0] imm;
  logic       reg_write, car_write, sel_imm, jump, mem_read, mem_write, mem2reg, done, halted;
  logic [2:0] level;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];
  bit          halted_m = 1'b0;
  bit          mon_en = 1'b0;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .instruction(instruction),
    .in_ready(in_ready), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .alu_op(alu_op), .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
    .imm(imm), .reg_write(reg_write), .car_write(car_write), .sel_imm(sel_imm),
    .jump(jump), .mem_read(mem_read), .mem_write(mem_write), .mem2reg(mem2reg),
    .done(done), .halted(halted), .level(level)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] actual_fields();
    return {alu_op, rs_addr, rt_addr, rd_addr, imm,
            reg_write, car_write, sel_imm, jump, mem_read, mem_write, mem2reg, done};
  endfunction

  // Spec-level decode table written with integer arithmetic.
  function automatic logic [31:0] ref_decode(input logic [8:0] i);
    int op, sub, a, b, alu, rs, rt, rd, im;
    bit rw, cw, si, j, mr, mw, m2r, dn;
    op = int'(i[8:6]); sub = int'(i[1:0]); a = int'(i[5:4]); b = int'(i[3:2]);
    alu = 0; rs = 0; rt = 0; rd = 0; im = 0;
    rw = 0; cw = 0; si = 0; j = 0; mr = 0; mw = 0; m2r = 0; dn = 0;
    case (op)
      0: if (sub == 3) begin alu = 7; rs = a; rt = b + 8; end
         else begin alu = sub; rs = a + 4; rt = b; rd = ACC; rw = 1; end
      1: case (sub)
           0: begin alu = 6; rs = b; rd = a + 4; rw = 1; mr = 1; m2r = 1; end
           1: begin alu = 6; rs = a + 4; rt = b; mw = 1; end
           2: begin alu = 4; rs = int'(i[5:2]); rd = rs; im = 1; si = 1; rw = 1; end
           default: begin alu = 3; rs = int'(i[5:2]); rd = rs; rw = 1; end
         endcase
      2, 4: begin alu = (op == 2) ? 4 : 5; rs = a + 4; rt = b; rd = sub + 8; rw = 1; cw = 1; end
      3: begin alu = 4; rs = b; rd = a + 8; im = sub; si = 1; rw = 1; end
      5: begin alu = 6; rs = int'(i[2:0]) + 5; rd = int'(i[5:3]) + 1; rw = 1; end
      6: begin alu = 6; im = i[5] ? int'(i[5:0]) - 64 : int'(i[5:0]); j = 1; end
      default: if (sub == 3) dn = 1;
               else begin alu = 8 + sub; rs = a + 4; rd = rs; rt = b; rw = 1; cw = 1; end
    endcase
    return {4'(alu), 4'(rs), 4'(rt), 4'(rd), 8'(im), rw, cw, si, j, mr, mw, m2r, dn};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare against the model, then advance the model across the next edge.
  always @(negedge clk) begin
    int sz;
    bit ir_m;
    bit done_pop;
    if (mon_en) begin
      sz   = exp_q.size();
      ir_m = !halted_m && (sz < DEPTH || out_ready);
      chk("level", 32'(level), 32'(sz));
      chk("in_ready", 32'(in_ready), 32'(ir_m));
      chk("halted", 32'(halted), 32'(halted_m));
      chk("out_valid", 32'(out_valid), 32'(sz != 0));
      if (sz != 0) chk("head", actual_fields(), exp_q[0]);
      else         chk("idle_fields", actual_fields(), 32'd0);
      if (flush) begin
        exp_q.delete();
      end else begin
        done_pop = 1'b0;
        if (sz != 0 && out_ready) begin
          done_pop = exp_q[0][0];
          void'(exp_q.pop_front());
        end
        if (done_pop) begin
          exp_q.delete();
          halted_m = 1'b1;
        end else if (in_valid && ir_m) begin
          exp_q.push_back(ref_decode(instruction));
        end
      end
    end
  end

  task automatic drive(input bit v, input logic [8:0] ins, input bit ordy, input bit fl);
    in_valid = v; instruction = ins; out_ready = ordy; flush = fl;
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_fields"}, actual_fields(), 32'd0);
    chk({tag, "_flags"}, {28'd0, out_valid, in_ready, halted, 1'b0}, 32'd0);
    chk({tag, "_level"}, 32'(level), 32'd0);
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    mon_en = 1'b1;
  endtask

  initial begin
    logic [8:0] r_ins;
    rst_n = 1'b0; in_valid = 1'b0; instruction = 9'd0; out_ready = 1'b0; flush = 1'b0;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    release_reset();

    // ADD 0x09B: head appears one cycle after accept.
    drive(1'b1, 9'h09B, 1'b1, 1'b0);
    chk("add_direct", actual_fields(), 32'h452B00C0);
    drive(1'b0, 9'h000, 1'b1, 1'b0);

    // Fill to DEPTH with the consumer stalled, then push+pop while full.
    drive(1'b1, 9'h0A1, 1'b0, 1'b0);
    drive(1'b1, 9'h046, 1'b0, 1'b0);
    drive(1'b1, 9'h1E9, 1'b0, 1'b0);
    drive(1'b1, 9'h0F7, 1'b0, 1'b0);
    chk("full_level", 32'(level), 32'd4);
    drive(1'b1, 9'h145, 1'b1, 1'b0);
    chk("full_pushpop_level", 32'(level), 32'd4);
    repeat (5) drive(1'b0, 9'h000, 1'b1, 1'b0);

    // JR and INC.
    drive(1'b1, 9'h1A0, 1'b1, 1'b0);
    chk("jr_direct", actual_fields(), 32'h6000E010);
    drive(1'b1, 9'h06E, 1'b1, 1'b0);
    chk("inc_direct", actual_fields(), 32'h4B0B01A0);
    drive(1'b0, 9'h000, 1'b1, 1'b0);

    // Flush at level 3 with a simultaneous push.
    repeat (3) drive(1'b1, 9'h0D2, 1'b0, 1'b0);
    drive(1'b1, 9'h09B, 1'b1, 1'b1);
    chk("flush_level", {28'd0, out_valid, level}, 32'd0);
    drive(1'b0, 9'h000, 1'b1, 1'b0);

    // Randomized traffic without DONE.
    for (int n = 0; n < 400; n++) begin
      r_ins = 9'($urandom);
      if (r_ins[8:6] == 3'b111 && r_ins[1:0] == 2'b11) r_ins[0] = 1'b0;
      drive(($urandom % 4) != 0, r_ins, ($urandom % 3) != 0, ($urandom % 25) == 0);
    end

    // Reset mid-stream with a non-empty queue.
    drive(1'b0, 9'h000, 1'b1, 1'b0);
    repeat (3) drive(1'b1, 9'h0B3, 1'b0, 1'b0);
    #2;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    halted_m = 1'b0;
    in_valid = 1'b0;
    release_reset();

    // DONE followed by ADD: ADD is dropped and the stage halts.
    drive(1'b1, 9'h1C3, 1'b1, 1'b0);
    drive(1'b1, 9'h09B, 1'b1, 1'b0);
    chk("halt_direct", {28'd0, halted, in_ready, out_valid, 1'b0}, 32'h8);
    repeat (4) drive(1'b1, 9'h09B, 1'b1, 1'b0);
    drive(1'b0, 9'h000, 1'b1, 1'b1);
    chk("halt_sticky_flush", 32'(halted), 32'd1);

    // Reset clears halted.
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check_reset_outputs("final_reset");
    exp_q.delete();
    halted_m = 1'b0;
    in_valid = 1'b0;
    release_reset();
    repeat (2) drive(1'b0, 9'h000, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
- REQ-001 SHALL have parameter NUM_REGS, default 12: register-file entries; register address width RA = $clog2(NUM_REGS+1).
- REQ-002 SHALL have parameter INSTR_WIDTH, default 9: instruction width; the decode table applies to bits [8:0].
- REQ-003 SHALL have parameter REG_WIDTH, default 8: immediate width.
- REQ-004 SHALL have parameter OP_WIDTH, default 4: ALU opcode width.
- REQ-005 SHALL have parameter DEPTH, default 4 (power of two, >=2): decoded-op queue depth.
- REQ-006 SHALL have ports, in order:
  - clk, input, 1: clock. One clock; reset is asynchronous and active-low.
  - rst_n, input, 1: reset.
  - in_valid, input, 1: instruction offered.
  - instruction, input, INSTR_WIDTH: raw instruction.
  - in_ready, output, 1: instruction accepted when in_valid&&in_ready.
  - flush, input, 1: discard all queued ops.
  - out_valid, output, 1: head op valid.
  - out_ready, input, 1: consumer takes head.
  - alu_op, output, OP_WIDTH: ALU opcode.
  - rs_addr/rt_addr/rd_addr, output, RA each: register addresses.
  - imm, output, REG_WIDTH: immediate.
  - reg_write/car_write/sel_imm/jump/mem_read/mem_write/mem2reg/done, output, 1 each: decoded control bits.
  - halted, output, 1: done op has issued.
  - level, output, $clog2(DEPTH)+1: queue occupancy.

Function
- REQ-007 SHALL decode by op=i[8:6], sub=i[1:0], with ACC=NUM_REGS:
  - op 000, sub 0/1/2 = AND/SLT/OR: alu 0/1/2; rs=i[5:4]+4; rt=i[3:2]; rd=ACC; reg_write.
  - op 000, sub 3 = BEQ: alu 7; rs=i[5:4]; rt=i[3:2]+8; no write.
  - op 001, sub 0 = LW: alu 6; rs=i[3:2]; rd=i[5:4]+4; reg_write, mem_read, mem2reg.
  - op 001, sub 1 = SW: alu 6; rs=i[5:4]+4; rt=i[3:2]; mem_write; no reg_write.
  - op 001, sub 2 = INC: alu 4; rs=rd=i[5:2]; imm=1; sel_imm; reg_write.
  - op 001, sub 3 = NOT: alu 3; rs=rd=i[5:2]; reg_write.
  - op 010 = ADD and op 100 = SUB: alu 4 / 5; rs=i[5:4]+4; rt=i[3:2]; rd=i[1:0]+8; reg_write, car_write.
  - op 011 = ADDI: alu 4; rs=i[3:2]; rd=i[5:4]+8; imm=zero-extended i[1:0]; sel_imm; reg_write.
  - op 101 = TR: alu 6; rs=i[2:0]+5; rd=i[5:3]+1; reg_write.
  - op 110 = JR: alu 6; imm=sign-extended i[5:0]; jump.
  - op 111, sub 0/1/2 = SRL/SRA/SLL: alu 8/9/10; rs=rd=i[5:4]+4; rt=i[3:2]; reg_write, car_write.
  - op 111, sub 3 = DONE: done.
- REQ-008 SHALL drive every field not listed for an op to 0; no X outputs.
- REQ-009 SHALL enqueue the decoded op on accept; out_valid rises the cycle after accept into an empty queue (latency 1); there is no combinational bypass.
- REQ-010 SHALL set in_ready = !halted && (level<DEPTH || out_ready); push and pop in the same cycle when full SHALL be legal.
- REQ-011 SHALL hold all output fields stable while out_valid && !out_ready.
- REQ-012 SHALL pop on out_valid && out_ready; the queue order is FIFO, and read/write pointers SHALL wrap modulo DEPTH.
- REQ-013 SHALL set halted the cycle after a DONE op pops; halted is sticky until reset, and ops behind DONE SHALL be discarded.
- REQ-014 SHALL empty the queue (level=0, out_valid=0) the cycle after flush; flush SHALL override a simultaneous push and pop, and SHALL not clear halted.

Reset
- REQ-015 SHALL, with rst_n low, asynchronously clear the pointers, level, out_valid, halted, and all output fields to 0; in_ready=0 during reset and 1 after release.

Configuration
- REQ-016 SHALL, under macro DECODE_PERF_EN, add outputs issue_cnt[15:0] (pops) and stall_cnt[15:0] (out_valid&&!out_ready cycles), both saturating, with reset 0; without the macro these ports SHALL be absent and behaviour is otherwise identical.

Structure
- REQ-017 SHALL place the ALU opcode constants, the op/sub field enums, ACC, and a packed decoded_op_t struct in package decode_pkg.
- REQ-018 SHALL implement decode in the combinational sub-module decode_logic (instruction -> decoded_op_t); decode_stage holds the queue and control.

Verification
- REQ-019 SHALL cover: ADD 0x09B (010_01_10_11), out_ready=1 -> next cycle alu=4, rs=5, rt=2, rd=11, reg_write=1, car_write=1.
- REQ-020 SHALL cover: out_ready=0, 4 pushes -> level=4, in_ready=0; then push+pop in one cycle -> level stays 4 and order is preserved.
- REQ-021 SHALL cover: JR 0x1A0 -> imm=0xE0, jump=1; INC 0x06E -> rs=rd=11, imm=1, sel_imm=1.
- REQ-022 SHALL cover: DONE 0x1C3 followed by ADD -> halted=1 the cycle after DONE pops, the ADD never appears, and in_ready=0.
- REQ-023 SHALL cover: level=3 with flush and in_valid asserted together -> next cycle level=0 and out_valid=0.
- REQ-024 SHALL cover: rst_n low mid-stream -> all outputs 0 immediately without a clock edge.
